ram_arbiter_2req: RTL and testbench
===================================

# ram_arbiter_2req

Round-robin arbiter that shares the single-port 1K x 4 RAM (`ram_dp1_1Kx4`) between two requesters. Requester 0 is the manual switch/button port and requester 1 is an automatic scanner or display-refresh engine. The block serialises accesses, registers the RAM control signals, and routes each read result back to the requester that issued it. It sits between the `adpt_in`-side logic and the RAM instance, in the same clock domain as the RAM's `inclock`.

## Interface
- `AW`, 10, RAM address width.
- `DW`, 4, RAM data width.
- `RD_LAT`, 1, RAM read latency in cycles from the address edge to valid `ram_q`. Legal values are 1 and 2.

- `clk`  in  1  single clock; RAM `inclock` is driven by the same net
- `rst`  in  1  synchronous, active-high reset
- `req0`, `req1`  in  1  access request; held, with its command stable, until granted
- `we0`, `we1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  AW  access address
- `wdata0`, `wdata1`  in  DW  write data
- `gnt0`, `gnt1`  out  1  one-cycle accept pulse
- `rvalid0`, `rvalid1`  out  1  one-cycle read-data-valid pulse
- `rdata0`, `rdata1`  out  DW  read data, valid while the matching `rvalid` is high
- `ram_addr`  out  AW  to RAM `address`
- `ram_data`  out  DW  to RAM `data`
- `ram_wren`  out  1  to RAM `wren`
- `ram_q`  in  DW  from RAM `q`

## Operation
- Grant selection is combinational within a cycle.
  - At most one of `gnt0`/`gnt1` is high in any cycle.
  - With `rst` high, both grants are 0.
- Priority pointer `prio` is 1 bit, reset value 0.
  - If only one requester asserts `req`, it is granted.
  - If both assert, the requester equal to `prio` is granted.
  - After any grant, `prio` becomes the index of the non-granted requester. This gives strict alternation under continuous contention.
  - If there is no grant, `prio` is unchanged.
- Command capture on the clock edge ending a grant cycle:
  - `ram_addr` and `ram_data` take the granted requester's values.
  - `ram_wren` takes the granted `we`.
- In any cycle without a grant:
  - `ram_wren` is registered to 0.
  - `ram_addr` and `ram_data` hold their previous values.
- Read-return pipeline:
  - A shift register of depth `RD_LAT + 1` carries {valid, owner} for every granted read.
  - When an entry reaches the output stage, the owner's `rvalid` pulses and its `rdata` is loaded from `ram_q`.
  - The non-owner's `rdata` holds its previous value.
- Writes produce no `rvalid`.
- Read-after-write ordering is preserved, because commands reach the RAM in grant order.
- A requester may assert a new command in the cycle after its grant.
  - Back-to-back grants to the same requester are allowed when the other requester is idle.
  - Throughput is 1 access per cycle.

## Timing
- Reset values (all outputs):
  - `ram_addr` = 0, `ram_data` = 0, `ram_wren` = 0.
  - `gnt0`/`gnt1` = 0, `rvalid0`/`rvalid1` = 0, `rdata0`/`rdata1` = 0.
  - `prio` = 0.
- Grant in cycle N means:
  - RAM command is presented in cycle N+1.
  - RAM samples it at the end of N+1.
  - For a write, memory is updated after N+1.
- Read granted in cycle N:
  - `rvalid` is high in cycle N+2+`RD_LAT` (N+3 for `RD_LAT`=1), registered.
  - Total request-to-data latency is therefore 3 cycles when `RD_LAT`=1.
- Simultaneous events:
  - Both `req` rising in the same cycle: the requester indexed by `prio` wins. Immediately after reset, requester 0 wins.
  - A request dropped before its grant is allowed; no access is issued for it.
- Reset mid-operation (`rst` high in any cycle):
  - Next cycle, the pipeline valid bits clear, `ram_wren` is 0 and `prio` is 0.
  - In-flight reads never produce `rvalid`.
  - Grants are suppressed throughout reset.
- Address wrap: addresses are used unmodified. 10'h3FF is a legal access; the arbiter performs no auto-increment.

## Test plan
- Reset check: hold `rst` 3 cycles while both `req` are high.
  - Required: no `gnt`, `ram_wren`=0, `ram_addr`=0, no `rvalid`.
  - First cycle after release: `gnt0`=1.
- Single write then read on requester 0: write addr 10'h005 with data 4'hA, next cycle read 10'h005.
  - Required: `ram_wren`=1 for exactly one cycle with `ram_addr`=10'h005.
  - `rvalid0` 3 cycles after the read grant, with `rdata0`=4'hA; `rvalid1` stays 0.
- Contention: both requesters request continuously for 6 cycles.
  - Required: grant sequence 0,1,0,1,0,1.
  - Requester 1 reads 10'h3FF, preloaded with 4'h7, and receives `rdata1`=4'h7 on `rvalid1` only.
- Interleaved read routing:
  - req0 reads 10'h010 (=4'h3) and req1 reads 10'h011 (=4'hC) in alternate cycles.
  - Required: `rvalid0`/`rdata0`=4'h3 and `rvalid1`/`rdata1`=4'hC in consecutive cycles, correctly steered.
- Reset mid-read: assert `rst` for 1 cycle one cycle after a read grant.
  - Required: no `rvalid` for that read.
  - `prio` returns to 0, so the next contended grant goes to requester 0.
- `RD_LAT`=2 build: repeat the single write-then-read scenario.
  - Required: `rvalid0` 4 cycles after the read grant, with correct data.

Source files
------------

// File: rtl/ram_arbiter_2req.sv
// Round-robin arbiter sharing one single-port RAM between two requesters.
// Grants are combinational; RAM command and read-return outputs are registered.
module ram_arbiter_2req #(
  parameter int AW     = 10,
  parameter int DW     = 4,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q
);

  localparam int DEPTH = RD_LAT + 1;

  logic             prio_r;
  logic             gnt0_s;
  logic             gnt1_s;
  logic             rd_issue_s;
  logic [DEPTH-1:0] pipe_valid_r;
  logic [DEPTH-1:0] pipe_owner_r;

  // Grant selection: a lone requester wins, contention goes to prio_r.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0 && req1) begin
      if (prio_r == 1'b0) begin
        gnt0_s = 1'b1;
      end else begin
        gnt1_s = 1'b1;
      end
    end else begin
      gnt0_s = req0;
      gnt1_s = req1;
    end
  end

  assign gnt0       = gnt0_s;
  assign gnt1       = gnt1_s;
  assign rd_issue_s = (gnt0_s && !we0) || (gnt1_s && !we1);

  // Priority pointer and registered RAM command.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_wren <= 1'b0;
    end else if (gnt0_s) begin
      prio_r   <= 1'b1;
      ram_addr <= addr0;
      ram_data <= wdata0;
      ram_wren <= we0;
    end else if (gnt1_s) begin
      prio_r   <= 1'b0;
      ram_addr <= addr1;
      ram_data <= wdata1;
      ram_wren <= we1;
    end else begin
      ram_wren <= 1'b0;
    end
  end

  // Read-return pipeline: stage RD_LAT lines up with valid ram_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid_r <= '0;
      pipe_owner_r <= '0;
      rvalid0      <= 1'b0;
      rvalid1      <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
    end else begin
      pipe_valid_r <= {pipe_valid_r[DEPTH-2:0], rd_issue_s};
      pipe_owner_r <= {pipe_owner_r[DEPTH-2:0], gnt1_s};
      rvalid0      <= pipe_valid_r[RD_LAT] && !pipe_owner_r[RD_LAT];
      rvalid1      <= pipe_valid_r[RD_LAT] && pipe_owner_r[RD_LAT];
      if (pipe_valid_r[RD_LAT] && !pipe_owner_r[RD_LAT]) begin
        rdata0 <= ram_q;
      end else begin
        rdata0 <= rdata0;
      end
      if (pipe_valid_r[RD_LAT] && pipe_owner_r[RD_LAT]) begin
        rdata1 <= ram_q;
      end else begin
        rdata1 <= rdata1;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter_2req.sv
// Bench for ram_arbiter_2req: RD_LAT=1 and RD_LAT=2 instances share stimulus,
// each with its own RAM model and a scoreboard of expected read returns.
module tb_ram_arbiter_2req;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, req0, req1, we0, we1, init_mem;
  logic [9:0] addr0, addr1;
  logic [3:0] wdata0, wdata1;

  logic [1:0]      gnt0, gnt1, rv0, rv1, ram_wren;
  logic [1:0][3:0] rd0, rd1, ram_data, ram_q;
  logic [1:0][9:0] ram_addr;

  logic [3:0] mem [2][1024];
  logic [3:0] q1 [2];
  logic [3:0] q2 [2];

  typedef struct {
    int         due;
    logic       owner;
    logic [3:0] data;
  } exp_t;

  exp_t       sb [2][$];
  logic [3:0] ref_mem [1024];
  logic       ref_prio = 1'b0;
  int         cyc, errors, checks;

  ram_arbiter_2req #(.AW(10), .DW(4), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]), .rvalid0(rv0[0]), .rvalid1(rv1[0]),
    .rdata0(rd0[0]), .rdata1(rd1[0]), .ram_addr(ram_addr[0]),
    .ram_data(ram_data[0]), .ram_wren(ram_wren[0]), .ram_q(ram_q[0])
  );

  ram_arbiter_2req #(.AW(10), .DW(4), .RD_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]), .rvalid0(rv0[1]), .rvalid1(rv1[1]),
    .rdata0(rd0[1]), .rdata1(rd1[1]), .ram_addr(ram_addr[1]),
    .ram_data(ram_data[1]), .ram_wren(ram_wren[1]), .ram_q(ram_q[1])
  );

  function automatic logic [3:0] pat(input int i);
    logic [9:0] a;
    a = i[9:0];
    if (a == 10'h3FF) return 4'h7;
    else if (a == 10'h010) return 4'h3;
    else if (a == 10'h011) return 4'hC;
    else return a[3:0] ^ a[7:4] ^ {2'b00, a[9:8]};
  endfunction

  // Single-port RAM models: registered read, plus an extra stage for RD_LAT=2.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (init_mem) begin
        for (int i = 0; i < 1024; i++) mem[k][i] <= pat(i);
      end else if (ram_wren[k]) begin
        mem[k][ram_addr[k]] <= ram_data[k];
      end
      q1[k] <= mem[k][ram_addr[k]];
      q2[k] <= q1[k];
    end
  end
  assign ram_q[0] = q1[0];
  assign ram_q[1] = q2[1];

  // One clock cycle: check grants and read returns mid-cycle, then update the model.
  task automatic tick();
    exp_t e;
    logic mg0, mg1, want_rv0, want_rv1;
    @(negedge clk);
    mg0 = !rst && req0 && (!req1 || ref_prio == 1'b0);
    mg1 = !rst && req1 && (!req0 || ref_prio == 1'b1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (gnt0[k] !== mg0 || gnt1[k] !== mg1) begin
        errors++;
        $display("FAIL grant dut%0d cyc=%0d got gnt1,gnt0=%b%b want %b%b",
                 k, cyc, gnt1[k], gnt0[k], mg1, mg0);
      end
      checks++;
      if (sb[k].size() > 0 && sb[k][0].due == cyc) begin
        e = sb[k].pop_front();
        want_rv0 = !e.owner;
        want_rv1 = e.owner;
        if (rv0[k] !== want_rv0 || rv1[k] !== want_rv1 ||
            (e.owner ? rd1[k] : rd0[k]) !== e.data) begin
          errors++;
          $display("FAIL rdata dut%0d cyc=%0d got rv0=%b rv1=%b rd0=%h rd1=%h want owner=%0d data=%h",
                   k, cyc, rv0[k], rv1[k], rd0[k], rd1[k], e.owner, e.data);
        end
      end else if (rv0[k] !== 1'b0 || rv1[k] !== 1'b0) begin
        errors++;
        $display("FAIL spurious_rvalid dut%0d cyc=%0d got rv0=%b rv1=%b want 00",
                 k, cyc, rv0[k], rv1[k]);
      end
    end
    @(posedge clk);
    if (rst) begin
      ref_prio = 1'b0;
      for (int k = 0; k < 2; k++) begin
        while (sb[k].size() > 0 && sb[k][sb[k].size()-1].due > cyc) void'(sb[k].pop_back());
      end
    end else if (mg0) begin
      if (we0) ref_mem[addr0] = wdata0;
      else for (int k = 0; k < 2; k++)
        sb[k].push_back('{due: cyc + 3 + k, owner: 1'b0, data: ref_mem[addr0]});
      ref_prio = 1'b1;
    end else if (mg1) begin
      if (we1) ref_mem[addr1] = wdata1;
      else for (int k = 0; k < 2; k++)
        sb[k].push_back('{due: cyc + 3 + k, owner: 1'b1, data: ref_mem[addr1]});
      ref_prio = 1'b0;
    end
    cyc++;
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 10 && (sb[0].size() > 0 || sb[1].size() > 0); i++) tick();
    checks++;
    if (sb[0].size() != 0 || sb[1].size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d/%0d want 0/0", sb[0].size(), sb[1].size());
    end
  endtask

  task automatic check_ram(input string name, input logic wren, input logic [9:0] addr);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ram_wren[k] !== wren || ram_addr[k] !== addr) begin
        errors++;
        $display("FAIL %s dut%0d cyc=%0d got wren=%b addr=%h want wren=%b addr=%h",
                 name, k, cyc, ram_wren[k], ram_addr[k], wren, addr);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 10'h100; addr1 = 10'h200;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_ram("reset_ram", 1'b0, 10'h000);
      tick();
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (gnt0[k] !== 1'b1 || gnt1[k] !== 1'b0) begin
        errors++;
        $display("FAIL first_grant dut%0d got gnt1,gnt0=%b%b want 01", k, gnt1[k], gnt0[k]);
      end
    end
    tick();
    req0 = 1'b0;
    tick();
    req1 = 1'b0;
    wait_drain();
  endtask

  task automatic test_write_read();
    #1;
    check_ram("wr_before", 1'b0, 10'h200);
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h005; wdata0 = 4'hA;
    tick();
    we0 = 1'b0;
    #1;
    check_ram("wr_cmd", 1'b1, 10'h005);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ram_data[k] !== 4'hA) begin
        errors++;
        $display("FAIL wr_data dut%0d got %h want a", k, ram_data[k]);
      end
    end
    tick();
    req0 = 1'b0;
    #1;
    check_ram("rd_cmd", 1'b0, 10'h005);
    tick();
    check_ram("idle_after", 1'b0, 10'h005);
    wait_drain();
  endtask

  task automatic test_interleave();
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h010;
    tick();
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 10'h011;
    tick();
    req1 = 1'b0;
    wait_drain();
  endtask

  task automatic test_contention();
    logic want0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr1 = 10'h3FF;
    for (int i = 0; i < 6; i++) begin
      addr0 = 10'h020 + 10'(i / 2);
      want0 = (i % 2 == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (gnt0[k] !== want0 || gnt1[k] !== !want0) begin
          errors++;
          $display("FAIL contention dut%0d step=%0d got gnt1,gnt0=%b%b want %b%b",
                   k, i, gnt1[k], gnt0[k], !want0, want0);
        end
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_mid_read();
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h010;
    tick();
    req0 = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 10'h011; addr1 = 10'h012;
    #1;
    check_ram("post_reset", 1'b0, 10'h000);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (gnt0[k] !== 1'b1 || gnt1[k] !== 1'b0) begin
        errors++;
        $display("FAIL prio_after_reset dut%0d got gnt1,gnt0=%b%b want 01", k, gnt1[k], gnt0[k]);
      end
    end
    tick();
    req0 = 1'b0;
    tick();
    req1 = 1'b0;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h3FF; wdata0 = 4'h5;
    tick();
    we0 = 1'b0;
    #1;
    check_ram("b2b_wr_top", 1'b1, 10'h3FF);
    tick();
    we0 = 1'b1; addr0 = 10'h000; wdata0 = 4'h9;
    #1;
    check_ram("b2b_rd_top", 1'b0, 10'h3FF);
    tick();
    we0 = 1'b0;
    #1;
    check_ram("b2b_wr_zero", 1'b1, 10'h000);
    tick();
    req0 = 1'b0;
    #1;
    check_ram("b2b_rd_zero", 1'b0, 10'h000);
    tick();
    wait_drain();
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
    rst = 1'b1; init_mem = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 10'h000; addr1 = 10'h000; wdata0 = 4'h0; wdata1 = 4'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
    @(posedge clk);
    #1;
    init_mem = 1'b0;
    cyc = 1;
    test_reset();
    test_write_read();
    test_interleave();
    test_contention();
    test_reset_mid_read();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
